rb_beat_packer: RTL and testbench

//  Width up-converter on the consume side of the sync FIFO.

---
 rtl/rb_beat_packer.sv | 61 ++++++
 tb/tb_rb_beat_packer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rb_beat_packer.sv
// rb_beat_packer: packs PACK narrow beats into one wide registered word, closed early by i_last.
module rb_beat_packer #(
  parameter int DW   = 8,
  parameter int PACK = 4,
  parameter int CW   = $clog2(PACK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [DW-1:0]      i_data,
  input  logic               i_last,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [DW*PACK-1:0] o_data,
  output logic [PACK-1:0]    o_keep,
  output logic               o_last,
  output logic               busy
);
  if (PACK < 2) begin : g_bad_pack
    $error("rb_beat_packer: PACK must be >= 2");
  end
  logic [CW-1:0]      count;
  logic [DW*PACK-1:0] acc;
  logic [DW*PACK-1:0] merged;
  logic [PACK-1:0]    keep_n;
  logic               fire;
  logic               done;
  assign i_ready = !o_valid | o_ready;
  assign fire    = i_valid & i_ready;
  assign done    = fire & ((count == CW'(PACK - 1)) | i_last);
  assign busy    = count != '0;
  // lanes at and above count are always zero, so OR-ing the new beat in is enough
  assign merged  = acc | ((DW*PACK)'(i_data) << (DW * count));
  for (genvar k = 0; k < PACK; k++) begin : g_keep
    assign keep_n[k] = CW'(k) <= count;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
    end else begin
      if (o_valid & o_ready) o_valid <= 1'b0;
      if (done) begin
        o_valid <= 1'b1;
        o_data  <= merged;
        o_keep  <= keep_n;
        o_last  <= i_last;
        count   <= '0;
        acc     <= '0;
      end else if (fire) begin
        acc   <= merged;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rb_beat_packer.sv
// tb_rb_beat_packer: directed vector table plus reset corner sequences for rb_beat_packer.
module tb_rb_beat_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [7:0]  i_data = '0;
  logic        i_last = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;
  logic        busy;
  int          n_total = 0;
  int          n_pass = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  ok;
    logic        ol;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  rb_beat_packer #(.DW(8), .PACK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep),
    .o_last(o_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic r, logic ir,
                              logic ov, logic [31:0] od, logic [3:0] ok, logic ol, logic bz);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r; t.ir = ir;
    t.ov = ov; t.od = od; t.ok = ok; t.ol = ol; t.bz = bz;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic step(input vec_t t, input string n);
    @(negedge clk);
    i_valid = t.v; i_data = t.d; i_last = t.l; o_ready = t.r;
    #1 chk({n, ".i_ready"}, 32'(i_ready), 32'(t.ir));
    @(posedge clk);
    #1;
    chk({n, ".o_valid"}, 32'(o_valid), 32'(t.ov));
    chk({n, ".busy"}, 32'(busy), 32'(t.bz));
    if (t.ov) begin
      chk({n, ".o_data"}, o_data, t.od);
      chk({n, ".o_keep"}, 32'(o_keep), 32'(t.ok));
      chk({n, ".o_last"}, 32'(o_last), 32'(t.ol));
    end
  endtask

  task automatic reset_chk(input string n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({n, ".o_valid"}, 32'(o_valid), 32'd0);
    chk({n, ".o_data"}, o_data, 32'd0);
    chk({n, ".o_keep"}, 32'(o_keep), 32'd0);
    chk({n, ".o_last"}, 32'(o_last), 32'd0);
    chk({n, ".busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
  endtask

  initial begin
    // v, d, l, r | ir, ov, od, ok, ol, busy
    tbl.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1, 0));
    tbl.push_back(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h06, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h07, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h08, 0, 1, 1, 1, 32'h08070605, 4'hF, 0, 0));
    // single-lane word loaded in the same cycle the previous word retires
    tbl.push_back(mk(1, 8'h5A, 1, 1, 1, 1, 32'h0000005A, 4'h1, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'h61 + 8'(i), 0, 0, 0, 1, 32'h0000005A, 4'h1, 1, 0));
    tbl.push_back(mk(1, 8'h61, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h62, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h63, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 8'h64, 0, 1, 1, 1, 32'h64636261, 4'hF, 0, 0));
    tbl.push_back(mk(0, 8'hEE, 0, 0, 0, 1, 32'h64636261, 4'hF, 0, 0));
    tbl.push_back(mk(0, 8'hEE, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 1, 1, 0, 32'h0, 4'h0, 0, 0));

    #1;
    chk("por.o_valid", 32'(o_valid), 32'd0);
    chk("por.o_data", o_data, 32'd0);
    chk("por.o_keep", 32'(o_keep), 32'd0);
    chk("por.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // reset mid-word: partial lanes must not leak into the next word
    step(mk(1, 8'h71, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1), "rw0");
    step(mk(1, 8'h72, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1), "rw1");
    reset_chk("rst_mid_word");
    step(mk(1, 8'h81, 0, 0, 1, 0, 32'h0, 4'h0, 0, 1), "rw2");
    step(mk(1, 8'h82, 0, 0, 1, 0, 32'h0, 4'h0, 0, 1), "rw3");
    step(mk(1, 8'h83, 0, 0, 1, 0, 32'h0, 4'h0, 0, 1), "rw4");
    step(mk(1, 8'h84, 0, 0, 1, 1, 32'h84838281, 4'hF, 0, 0), "rw5");
    // reset while a word is stalled with a beat waiting
    step(mk(1, 8'h91, 0, 0, 0, 1, 32'h84838281, 4'hF, 0, 0), "rs0");
    reset_chk("rst_mid_stall");
    step(mk(1, 8'hA1, 1, 1, 1, 1, 32'h000000A1, 4'h1, 1, 0), "rs1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
